// File: rtl/cross_entropy_grad_inverse_pkg.sv
// ce_pkg: shared fixed-point constants, types and FSM states for the cross-entropy gradient blocks
package ce_pkg;
  localparam int FRAC_BITS = 12;
  localparam int ONE = 1 << FRAC_BITS;
  localparam int IN_W = 13;
  localparam int OUT_W = 12;
  localparam int REM_W = IN_W + 1;
  localparam int CNT_W = 4;
  typedef logic signed [IN_W-1:0] grad_t;
  typedef logic [OUT_W-1:0] prob_t;
  typedef logic [IN_W-1:0] div_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  // forward table code g = -floor(ONE/p); p==0 maps to the most negative code
  function automatic grad_t grad_of_prob(prob_t p);
    return (p == '0) ? grad_t'(-ONE) : grad_t'(-(ONE / int'(p)));
  endfunction
endpackage

// File: rtl/cross_entropy_grad_inverse_if.sv
// cross_entropy_grad_inverse_if: gradient-in / probability-out valid-ready bus
interface cross_entropy_grad_inverse_if;
  import ce_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready, sat, err;
  grad_t grad;
  prob_t prob;
  modport master (output in_valid, grad, out_ready, input in_ready, out_valid, prob, sat, err);
  modport slave (input in_valid, grad, out_ready, output in_ready, out_valid, prob, sat, err);
endinterface

// File: rtl/cross_entropy_grad_inverse_restoring_div_step.sv
// restoring_div_step: one combinational restoring-division iteration on {rem, quo} by m
module restoring_div_step
  import ce_pkg::*;
(
  input  logic [REM_W-1:0] rem,
  input  div_t             quo,
  input  div_t             m,
  output logic [REM_W-1:0] rem_next,
  output div_t             quo_next
);
  logic [REM_W:0] shifted;
  logic [REM_W-1:0] diff;
  logic ge;
  always_comb begin
    shifted = {rem, quo[IN_W-1]};
    ge = shifted >= {2'b0, m};
    diff = shifted[REM_W-1:0] - {1'b0, m};
    rem_next = ge ? diff : shifted[REM_W-1:0];
    quo_next = {quo[IN_W-2:0], ge};
  end
endmodule

// File: rtl/cross_entropy_grad_inverse.sv
// cross_entropy_grad_inverse: recovers p = floor(4096/|g|) from a gradient code with a bit-serial divider
module cross_entropy_grad_inverse
  import ce_pkg::*;
(
  input logic clk,
  input logic reset,
  cross_entropy_grad_inverse_if.slave bus
);
  state_t state, state_nx;
  logic [REM_W-1:0] rem, rem_nx;
  div_t quo, quo_nx, m;
  logic [CNT_W-1:0] cnt;
  prob_t prob_r;
  logic sat_r, err_r, accept, last;
  assign accept = bus.in_valid && bus.in_ready;
  assign last = cnt == CNT_W'(IN_W - 1);
  assign bus.prob = prob_r;
  assign bus.sat = sat_r;
  assign bus.err = err_r;
  restoring_div_step u_step (
    .rem(rem), .quo(quo), .m(m), .rem_next(rem_nx), .quo_next(quo_nx)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = !accept ? IDLE : bus.grad[IN_W-1] ? CALC : DONE;
      CALC: state_nx = last ? DONE : CALC;
      DONE: state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
  end
  // a quotient of 4096 (m==1) has its MSB set and is clamped to the largest code
  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      quo <= '0;
      m <= '0;
      cnt <= '0;
      prob_r <= '0;
      sat_r <= 1'b0;
      err_r <= 1'b0;
    end else if (accept) begin
      m <= div_t'(-bus.grad);
      rem <= '0;
      quo <= div_t'(ONE);
      cnt <= '0;
      if (!bus.grad[IN_W-1]) begin
        prob_r <= '1;
        sat_r <= 1'b0;
        err_r <= 1'b1;
      end
    end else if (state == CALC) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        prob_r <= quo_nx[IN_W-1] ? '1 : quo_nx[OUT_W-1:0];
        sat_r <= quo_nx[IN_W-1];
        err_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cross_entropy_grad_inverse.sv
// tb_cross_entropy_grad_inverse: vector table, corner sequences, random and round-trip checks against a division model
module tb_cross_entropy_grad_inverse;
  import ce_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  cross_entropy_grad_inverse_if bus();
  cross_entropy_grad_inverse dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_fail = 0;
  typedef struct {int grad; int hold; int prob; int sat; int err; int lat;} vec_t;
  vec_t vecs[7];
  function automatic int model_prob(int g);
    if (g >= 0 || g == -1) return 4095;
    return 4096 / (-g);
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic xact(input int g, input int hold, output int p, output int s, output int e, output int lat);
    int guard = 0;
    @(negedge clk);
    bus.grad = grad_t'(g);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = bus.prob;
    s = bus.sat;
    e = bus.err;
    for (int i = 0; i < hold; i++) begin
      if (i == hold / 2) begin
        bus.in_valid = 1'b1;
        bus.grad = grad_t'(-3);
      end
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_prob", bus.prob, p);
      chk("hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.grad = grad_t'(g);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    if (lat < 40) begin
      chk("post_out_valid", bus.out_valid, 0);
      chk("post_in_ready", bus.in_ready, 1);
      chk("post_prob_hold", bus.prob, p);
    end
  endtask
  initial begin
    int p, s, e, lat, g, h, last_g, last_p;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.grad = '0;
    vecs = '{'{-1365, 0, 3, 0, 0, 14}, '{-5, 0, 819, 0, 0, 14}, '{-1, 0, 4095, 1, 0, 14},
             '{-4096, 0, 1, 0, 0, 14}, '{0, 0, 4095, 0, 1, 1}, '{7, 0, 4095, 0, 1, 1},
             '{-64, 10, 64, 0, 0, 14}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_prob", bus.prob, 0);
    chk("rst_sat", bus.sat, 0);
    chk("rst_err", bus.err, 0);
    reset = 1'b0;
    foreach (vecs[i]) begin
      xact(vecs[i].grad, vecs[i].hold, p, s, e, lat);
      chk($sformatf("vec%0d_prob", i), p, vecs[i].prob);
      chk($sformatf("vec%0d_sat", i), s, vecs[i].sat);
      chk($sformatf("vec%0d_err", i), e, vecs[i].err);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end
    @(negedge clk);
    bus.grad = grad_t'(-512);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midcalc_rst_out_valid", bus.out_valid, 0);
    chk("midcalc_rst_in_ready", bus.in_ready, 1);
    reset = 1'b0;
    xact(-512, 0, p, s, e, lat);
    chk("after_rst_prob", p, 8);
    chk("after_rst_lat", lat, 14);
    for (int i = 0; i < 150; i++) begin
      g = ($urandom_range(9, 0) == 0) ? int'($urandom_range(4095, 0)) : -int'($urandom_range(4096, 1));
      h = int'($urandom_range(3, 0));
      xact(g, h, p, s, e, lat);
      chk($sformatf("rnd_prob g=%0d", g), p, model_prob(g));
      chk($sformatf("rnd_sat g=%0d", g), s, (g == -1) ? 1 : 0);
      chk($sformatf("rnd_err g=%0d", g), e, (g >= 0) ? 1 : 0);
      chk($sformatf("rnd_lat g=%0d", g), lat, (g >= 0) ? 1 : 14);
    end
    last_g = 1;
    last_p = 0;
    for (int q = 2; q <= 4095; q++) begin
      g = -(4096 / q);
      if (g != last_g) begin
        xact(g, 0, p, s, e, lat);
        chk($sformatf("trip_prob g=%0d", g), p, model_prob(g));
        last_g = g;
        last_p = p;
      end
      chk($sformatf("trip_table p=%0d", q), -(4096 / ((last_p == 0) ? 4096 : last_p)), g);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
